fb_pixel_writer: RTL

- Write-side port of the 64x48, 4-bit-per-pixel framebuffer memory whose read side is owned by the display pixel feeder.
- Accepts single-pixel writes (x, y, colour) over a valid/ready handshake and buffers them in a small FIFO.
- Drains the FIFO into memory only while the feeder is not on a memory-reading row, so display reads never collide with writes.
- Also provides a whole-screen fill engine.

---
 rtl/fb_pkg.sv | 28 ++
 rtl/fb_write_fifo.sv | 66 ++++++
 rtl/fb_pixel_writer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared types and constants for the 64x48, 4-bit-per-pixel framebuffer write path.
package fb_pkg;

    localparam int unsigned FB_COLS     = 64;
    localparam int unsigned FB_ROWS_MAX = 48;
    localparam int unsigned PIX_W       = 4;
    localparam int unsigned ADDR_W      = 9;
    localparam int unsigned SEL_W       = 3;

    typedef logic [PIX_W-1:0] pix_t;

    typedef struct packed {
        logic [5:0] x;
        logic [5:0] y;
        pix_t       pix;
    } wr_beat_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } writer_state_t;

    // One memory word holds eight pixels of a row; the low column bits pick the pixel.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [5:0] x, input logic [5:0] y);
        return {y, x[5:3]};
    endfunction

endpackage

// File: rtl/fb_write_fifo.sv
// Small synchronous FIFO of pixel write beats; head is read straight from the storage registers.
module fb_write_fifo
    import fb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic     clk_25,
    input  logic     rst_n,
    input  logic     push_i,
    input  wr_beat_t push_data_i,
    input  logic     pop_i,
    output wr_beat_t head_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    wr_beat_t       store_q [FIFO_DEPTH];
    logic [AW:0]    wr_ptr_q;
    logic [AW:0]    rd_ptr_q;
    logic [AW:0]    wr_ptr_d;
    logic [AW:0]    rd_ptr_d;
    logic           do_push_s;
    logic           do_pop_s;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign head_o    = store_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    always_ff @(posedge clk_25) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk_25) begin
        if (do_push_s) begin
            store_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/fb_pixel_writer.sv
// Framebuffer write port: buffered single-pixel writes plus an optional whole-screen fill,
// enabled by defining FB_PIXEL_WRITER_FILL_EN. Writes only issue while mem_row is low.
module fb_pixel_writer
    import fb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FB_ROWS    = FB_ROWS_MAX
) (
    input  logic              clk_25,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [5:0]        wr_x,
    input  logic [5:0]        wr_y,
    input  logic [PIX_W-1:0]  wr_pix,
    input  logic              fill_start,
    input  logic [PIX_W-1:0]  fill_pix,
    input  logic              mem_row,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [SEL_W-1:0]  mem_pix_sel,
    output logic [PIX_W-1:0]  mem_wdata,
    output logic              mem_we,
    output logic              busy,
    output logic              fill_done,
    output logic              err_oob,
    input  logic              err_clr
);

    localparam logic [5:0] LAST_ROW = 6'(FB_ROWS - 1);

    wr_beat_t    beat_in_s;
    wr_beat_t    head_s;
    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic        accept_s;
    logic        oob_s;
    logic        push_s;
    logic        pop_s;
    logic        err_oob_q;
    logic        err_oob_d;

    logic              we_s;
    logic [ADDR_W-1:0] addr_s;
    logic [SEL_W-1:0]  sel_s;
    pix_t              wdata_s;

    assign beat_in_s = '{x: wr_x, y: wr_y, pix: wr_pix};
    assign accept_s  = wr_valid && !fifo_full_s;
    assign oob_s     = (wr_y > LAST_ROW);
    assign push_s    = accept_s && !oob_s;
    assign wr_ready  = !fifo_full_s;

    fb_write_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_25      (clk_25),
        .rst_n       (rst_n),
        .push_i      (push_s),
        .push_data_i (beat_in_s),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

    always_comb begin
        err_oob_d = err_oob_q;
        if (accept_s && oob_s) begin
            err_oob_d = 1'b1;
        end else if (err_clr) begin
            err_oob_d = 1'b0;
        end else begin
            err_oob_d = err_oob_q;
        end
    end

    always_ff @(posedge clk_25) begin
        if (!rst_n) begin
            err_oob_q <= 1'b0;
        end else begin
            err_oob_q <= err_oob_d;
        end
    end

    assign err_oob = err_oob_q;

`ifdef FB_PIXEL_WRITER_FILL_EN
    localparam logic [5:0] LAST_COL = 6'(FB_COLS - 1);

    writer_state_t state_q, state_d;
    logic [5:0]    fill_x_q, fill_x_d;
    logic [5:0]    fill_y_q, fill_y_d;
    pix_t          fill_pix_q, fill_pix_d;
    logic          fill_done_q, fill_done_d;

    // Issue selection and fill sequencing; the FIFO is frozen while a fill runs.
    always_comb begin
        state_d     = state_q;
        fill_x_d    = fill_x_q;
        fill_y_d    = fill_y_q;
        fill_pix_d  = fill_pix_q;
        fill_done_d = 1'b0;
        we_s        = 1'b0;
        addr_s      = '0;
        sel_s       = '0;
        wdata_s     = '0;
        pop_s       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fill_start) begin
                    state_d    = S_FILL;
                    fill_pix_d = fill_pix;
                    fill_x_d   = 6'd0;
                    fill_y_d   = 6'd0;
                end else begin
                    state_d = S_IDLE;
                end
                if (rst_n && !mem_row && !fifo_empty_s) begin
                    we_s    = 1'b1;
                    addr_s  = pix_addr(head_s.x, head_s.y);
                    sel_s   = head_s.x[2:0];
                    wdata_s = head_s.pix;
                    pop_s   = 1'b1;
                end else begin
                    we_s  = 1'b0;
                    pop_s = 1'b0;
                end
            end
            S_FILL: begin
                if (rst_n && !mem_row) begin
                    we_s    = 1'b1;
                    addr_s  = pix_addr(fill_x_q, fill_y_q);
                    sel_s   = fill_x_q[2:0];
                    wdata_s = fill_pix_q;
                    if (fill_x_q == LAST_COL) begin
                        fill_x_d = 6'd0;
                        if (fill_y_q == LAST_ROW) begin
                            fill_y_d    = 6'd0;
                            state_d     = S_IDLE;
                            fill_done_d = 1'b1;
                        end else begin
                            fill_y_d = fill_y_q + 6'd1;
                        end
                    end else begin
                        fill_x_d = fill_x_q + 6'd1;
                    end
                end else begin
                    we_s = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_25) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            fill_x_q    <= 6'd0;
            fill_y_q    <= 6'd0;
            fill_pix_q  <= '0;
            fill_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_x_q    <= fill_x_d;
            fill_y_q    <= fill_y_d;
            fill_pix_q  <= fill_pix_d;
            fill_done_q <= fill_done_d;
        end
    end

    assign fill_done = fill_done_q;
    assign busy      = (state_q == S_FILL) || !fifo_empty_s;
`else
    logic unused_fill_s;
    assign unused_fill_s = ^{fill_start, fill_pix};

    // Without the fill engine the writer only ever drains the FIFO.
    always_comb begin
        we_s    = 1'b0;
        addr_s  = '0;
        sel_s   = '0;
        wdata_s = '0;
        pop_s   = 1'b0;
        if (rst_n && !mem_row && !fifo_empty_s) begin
            we_s    = 1'b1;
            addr_s  = pix_addr(head_s.x, head_s.y);
            sel_s   = head_s.x[2:0];
            wdata_s = head_s.pix;
            pop_s   = 1'b1;
        end else begin
            we_s  = 1'b0;
            pop_s = 1'b0;
        end
    end

    assign fill_done = 1'b0;
    assign busy      = !fifo_empty_s;
`endif

    assign mem_we      = we_s;
    assign mem_addr    = addr_s;
    assign mem_pix_sel = sel_s;
    assign mem_wdata   = wdata_s;

endmodule
